// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic multiplier slice.
package dsc_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dsc_state_e;

   // Widest flat operand vector / single operand the slice helper handles
   localparam int unsigned DSC_MAX_VEC = 64;
   localparam int unsigned DSC_MAX_W   = 32;

   // Run-length counter width: must hold 2^(N*W) itself, hence N*W+1 bits
   function automatic int unsigned run_len_w(input int unsigned n, input int unsigned w);
      return n * w + 1;
   endfunction

   // Extract operand idx of width w from a flat vector
   function automatic logic [DSC_MAX_W-1:0] op_slice(input logic [DSC_MAX_VEC-1:0] vec,
                                                     input int unsigned idx,
                                                     input int unsigned w);
      logic [DSC_MAX_VEC-1:0] mask;
      mask = (DSC_MAX_VEC'(1) << w) - DSC_MAX_VEC'(1);
      return DSC_MAX_W'((vec >> (idx * w)) & mask);
   endfunction

endpackage

// File: rtl/dsc_clkdiv_mul_if.sv
// Start/busy/done handshake and operand/result bus of the DSC multiplier.
interface dsc_clkdiv_mul_if #(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned NUM_INPUTS = 2
);
   logic                               start;
   logic [NUM_INPUTS*DATA_WIDTH-1:0]   bin_data_in;
   logic [NUM_INPUTS*DATA_WIDTH-1:0]   bin_data_out;
   logic                               busy;
   logic                               done;

   modport master (output start, bin_data_in, input bin_data_out, busy, done);
   modport slave  (input start, bin_data_in, output bin_data_out, busy, done);
endinterface

// File: rtl/dsc_unary_sng.sv
// Unary ones-first stream generator: W-bit counter, stream bit is (count < x).
module dsc_unary_sng #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] x_i,
   output logic         stream_c_o,
   output logic         wrap_c_o
);

   logic [W-1:0] cnt_q;

   // Channel counter: cleared on a new job, advances when enabled, wraps naturally
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign stream_c_o = (cnt_q < x_i);
   assign wrap_c_o   = en_i & (cnt_q == {W{1'b1}});

endmodule

// File: rtl/dsc_clkdiv_mul.sv
// Exact DSC multiplier with clock-division ordering on a single clock.
// Optional DSC_EARLY_TERM_EN: stop once the top operand's stream is exhausted.
module dsc_clkdiv_mul
   import dsc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned NUM_INPUTS = 2
) (
   input  logic            clk,
   input  logic            rst,
   dsc_clkdiv_mul_if.slave dsc_bus
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned N  = NUM_INPUTS;
   localparam int unsigned NW = N * W;

   dsc_state_e      state_q, state_d;
   logic [NW-1:0]   opnd_q, opnd_d;
   logic [NW-1:0]   acc_q, acc_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            clr_c, run_c, last_c, any_zero_c;
   logic [N-1:0]    b_c, wrap_c;

`ifdef DSC_EARLY_TERM_EN
   localparam int unsigned LW = run_len_w(N, W);
   logic [LW-1:0]   cnt_q, cnt_d, len_c;
   logic [W-1:0]    x_last_c;
`endif

   // Stream generators; each channel steps when every lower channel wraps
   for (genvar i = 0; i < N; i++) begin : g_ch
      logic         en_c;
      logic [W-1:0] x_c;
      if (i == 0) begin : g_head
         assign en_c = run_c;
      end else begin : g_tail
         assign en_c = wrap_c[i-1];
      end
      assign x_c = W'(op_slice(DSC_MAX_VEC'(opnd_q), i, W));
      dsc_unary_sng #(.W(W)) u_sng (
         .clk        (clk),
         .rst        (rst),
         .clr_i      (clr_c),
         .en_i       (en_c),
         .x_i        (x_c),
         .stream_c_o (b_c[i]),
         .wrap_c_o   (wrap_c[i])
      );
   end

   // Zero-operand bypass looks at the operands presented with start
   always_comb begin
      any_zero_c = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (W'(op_slice(DSC_MAX_VEC'(dsc_bus.bin_data_in), i, W)) == '0) begin
            any_zero_c = 1'b1;
         end
      end
   end

   // Last RUN cycle: top-channel wrap ends the full product space
`ifdef DSC_EARLY_TERM_EN
   always_comb begin
      x_last_c = W'(op_slice(DSC_MAX_VEC'(opnd_q), N - 1, W));
      len_c    = LW'(x_last_c) << ((N - 1) * W);
      last_c   = ((cnt_q + LW'(1)) == len_c) | wrap_c[N-1];
   end
`else
   assign last_c = wrap_c[N-1];
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (dsc_bus.start) state_d = any_zero_c ? DONE : RUN;
         RUN:  if (last_c)        state_d = DONE;
         DONE:                    state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      opnd_d = opnd_q;
      acc_d  = acc_q;
      clr_c  = 1'b0;
      run_c  = 1'b0;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
`ifdef DSC_EARLY_TERM_EN
      cnt_d  = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (dsc_bus.start) begin
               opnd_d = dsc_bus.bin_data_in;
               acc_d  = '0;
               clr_c  = 1'b1;
`ifdef DSC_EARLY_TERM_EN
               cnt_d  = '0;
`endif
            end
         end
         RUN: begin
            run_c = 1'b1;
            acc_d = acc_q + NW'(&b_c);
`ifdef DSC_EARLY_TERM_EN
            cnt_d = cnt_q + LW'(1);
`endif
         end
         default: ;
      endcase
   end

   // Datapath and handshake registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         opnd_q <= '0;
         acc_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef DSC_EARLY_TERM_EN
         cnt_q  <= '0;
`endif
      end else begin
         opnd_q <= opnd_d;
         acc_q  <= acc_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef DSC_EARLY_TERM_EN
         cnt_q  <= cnt_d;
`endif
      end
   end

   assign dsc_bus.bin_data_out = acc_q;
   assign dsc_bus.busy         = busy_q;
   assign dsc_bus.done         = done_q;

endmodule

// File: tb/tb_dsc_clkdiv_mul.sv
// Directed self-checking bench for dsc_clkdiv_mul (W=5/N=2 and W=3/N=3 instances).
module tb_dsc_clkdiv_mul;

   logic clk;
   logic rst;

   int n_chk;
   int n_err;

   // Latency from the start edge to the done cycle (L+1), hand-computed per build
`ifdef DSC_EARLY_TERM_EN
   localparam int LAT_37   = 225;
   localparam int LAT_3131 = 993;
   localparam int LAT_311  = 33;
   localparam int LAT_567  = 449;
   localparam int LAT_777  = 449;
`else
   localparam int LAT_37   = 1025;
   localparam int LAT_3131 = 1025;
   localparam int LAT_311  = 1025;
   localparam int LAT_567  = 513;
   localparam int LAT_777  = 513;
`endif

   dsc_clkdiv_mul_if #(.DATA_WIDTH(5), .NUM_INPUTS(2)) ifa ();
   dsc_clkdiv_mul_if #(.DATA_WIDTH(3), .NUM_INPUTS(3)) ifb ();

   dsc_clkdiv_mul #(.DATA_WIDTH(5), .NUM_INPUTS(2)) dut_a (
      .clk     (clk),
      .rst     (rst),
      .dsc_bus (ifa)
   );

   dsc_clkdiv_mul #(.DATA_WIDTH(3), .NUM_INPUTS(3)) dut_b (
      .clk     (clk),
      .rst     (rst),
      .dsc_bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One job on the W=5/N=2 instance; lat=0 means done never came
   task automatic go_a(input logic [4:0] x0, input logic [4:0] x1,
                       output int lat, output logic [9:0] res);
      @(negedge clk);
      ifa.bin_data_in = {x1, x0};
      ifa.start       = 1'b1;
      lat = 0;
      for (int n = 1; n <= 1200; n++) begin
         @(negedge clk);
         ifa.start = 1'b0;
         if (ifa.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      res = ifa.bin_data_out;
   endtask

   // One job on the W=3/N=3 instance
   task automatic go_b(input logic [2:0] x0, input logic [2:0] x1, input logic [2:0] x2,
                       output int lat, output logic [8:0] res);
      @(negedge clk);
      ifb.bin_data_in = {x2, x1, x0};
      ifb.start       = 1'b1;
      lat = 0;
      for (int n = 1; n <= 700; n++) begin
         @(negedge clk);
         ifb.start = 1'b0;
         if (ifb.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      res = ifb.bin_data_out;
   endtask

   int          lat;
   logic [9:0]  ra;
   logic [8:0]  rb;
   int          d1, d2, ndone;
   logic [9:0]  r1, r2;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b0;
      ifa.start = 1'b0;
      ifa.bin_data_in = '0;
      ifb.start = 1'b0;
      ifb.bin_data_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_out",  ifa.bin_data_out, 0);
      chk("rst_a_busy", ifa.busy, 0);
      chk("rst_a_done", ifa.done, 0);
      chk("rst_b_out",  ifb.bin_data_out, 0);
      chk("rst_b_busy", ifb.busy, 0);
      chk("rst_b_done", ifb.done, 0);
      rst = 1'b1;

      // Basic products and latencies
      go_a(5'd3, 5'd7, lat, ra);
      chk("a37_lat", lat, LAT_37);
      chk("a37_res", ra, 21);
      @(negedge clk);
      chk("a37_done_pulse", ifa.done, 0);
      chk("a37_busy_fall",  ifa.busy, 0);
      chk("a37_res_hold",   ifa.bin_data_out, 21);

      go_a(5'd31, 5'd31, lat, ra);
      chk("a3131_lat", lat, LAT_3131);
      chk("a3131_res", ra, 961);

      go_a(5'd31, 5'd1, lat, ra);
      chk("a311_lat", lat, LAT_311);
      chk("a311_res", ra, 31);

      // Zero-operand bypass
      go_a(5'd0, 5'd9, lat, ra);
      chk("a09_lat",  lat, 1);
      chk("a09_res",  ra, 0);
      chk("a09_busy", ifa.busy, 1);
      go_a(5'd9, 5'd0, lat, ra);
      chk("a90_lat", lat, 1);
      chk("a90_res", ra, 0);

      go_b(3'd5, 3'd6, 3'd7, lat, rb);
      chk("b567_lat", lat, LAT_567);
      chk("b567_res", rb, 210);
      go_b(3'd7, 3'd7, 3'd7, lat, rb);
      chk("b777_lat", lat, LAT_777);
      chk("b777_res", rb, 343);
      go_b(3'd5, 3'd0, 3'd7, lat, rb);
      chk("b507_lat", lat, 1);
      chk("b507_res", rb, 0);

      // Reset in the middle of a run aborts without a done pulse
      @(negedge clk);
      ifa.bin_data_in = {5'd7, 5'd3};
      ifa.start = 1'b1;
      ndone = 0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         ifa.start = 1'b0;
         if (ifa.done === 1'b1) ndone++;
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("mrst_out",  ifa.bin_data_out, 0);
      chk("mrst_busy", ifa.busy, 0);
      chk("mrst_done", ifa.done, 0);
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         if (ifa.done === 1'b1) ndone++;
      end
      chk("mrst_no_done", ndone, 0);
      go_a(5'd3, 5'd7, lat, ra);
      chk("mrst_fresh_lat", lat, LAT_37);
      chk("mrst_fresh_res", ra, 21);

      // start held high, operands disturbed mid-run
      @(negedge clk);
      ifa.bin_data_in = {5'd7, 5'd3};
      ifa.start = 1'b1;
      d1 = 0;
      d2 = 0;
      r1 = '0;
      r2 = '0;
      for (int n = 1; n <= 2 * LAT_37 + 20; n++) begin
         @(negedge clk);
         if (n == 50 || n == LAT_37 + 60) ifa.bin_data_in = {5'd30, 5'd17};
         if (ifa.done === 1'b1) begin
            if (d1 == 0) begin
               d1 = n;
               r1 = ifa.bin_data_out;
               ifa.bin_data_in = {5'd7, 5'd3};
            end else begin
               d2 = n;
               r2 = ifa.bin_data_out;
               ifa.start = 1'b0;
               break;
            end
         end
      end
      chk("b2b_first_lat", d1, LAT_37);
      chk("b2b_first_res", r1, 21);
      chk("b2b_second_res", r2, 21);
      chk("b2b_spacing", d2 - d1, LAT_37 + 1);
      @(negedge clk);
      chk("b2b_busy_fall", ifa.busy, 0);
      chk("b2b_done_pulse", ifa.done, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
